// File: rtl/seq_pack_pkg.sv
// Shared types and constants for the sequence frame packer.
package seq_pack_pkg;

    localparam int DATA_W      = 8;
    localparam int FRAME_CNT_W = 16;
    localparam int IDX_W       = 8;

    localparam logic [DATA_W-1:0] HDR_DEFAULT = 8'hA5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        SUM  = 2'd3
    } state_t;

    // Running checksum is a plain mod-256 byte sum.
    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/seq_pack_fifo.sv
// Synchronous FIFO with registered storage (no fall-through); a push while
// full is still accepted when a pop happens in the same cycle.
module seq_pack_fifo
    import seq_pack_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = DATA_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/seq_frame_packer.sv
// Buffers generator samples and emits header/payload/checksum frames on a
// valid/ready byte port. Define SEQ_FRAME_PACKER_DROP_CNT_EN for a drop counter.
module seq_frame_packer
    import seq_pack_pkg::*;
#(
    parameter int                FRAME_LEN  = 4,
    parameter int                FIFO_DEPTH = 8,
    parameter logic [DATA_W-1:0] HDR_BYTE   = HDR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   busy
`ifdef SEQ_FRAME_PACKER_DROP_CNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);

    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] csum;
    logic [DATA_W-1:0] head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [AW:0]       fifo_cnt;
    logic              hs;
    logic              drop;

    seq_pack_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (fifo_pop),
        .wdata (in_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign hs       = out_valid && out_ready;
    assign fifo_pop = (state == PAY) && hs;
    // The generator cannot stall: a full FIFO with no pop this cycle loses the sample.
    assign drop     = in_valid && fifo_full && !fifo_pop;
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_data  = '0;
        case (state)
            IDLE: begin
                if (fifo_cnt != '0) state_nxt = HDR;
            end
            HDR: begin
                out_valid = 1'b1;
                out_data  = HDR_BYTE;
                if (hs) state_nxt = PAY;
            end
            PAY: begin
                out_valid = !fifo_empty;
                out_data  = fifo_empty ? '0 : head;
                if (hs && idx == IDX_LAST) state_nxt = SUM;
            end
            SUM: begin
                out_valid = 1'b1;
                out_data  = csum;
                if (hs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            csum      <= '0;
            overflow  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (drop) overflow <= 1'b1;
            case (state)
                HDR: if (hs) begin
                    idx  <= '0;
                    csum <= '0;
                end
                PAY: if (hs) begin
                    idx  <= idx + 1'b1;
                    csum <= csum_add(csum, head);
                end
                SUM: if (hs) frame_cnt <= frame_cnt + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef SEQ_FRAME_PACKER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst)                          drop_cnt <= '0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_seq_frame_packer.sv
// Directed bench for seq_frame_packer with an expected-byte scoreboard.
module tb_seq_frame_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic        busy;
`ifdef SEQ_FRAME_PACKER_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb[$];

    always #5 clk = ~clk;

    seq_frame_packer #(
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8),
        .HDR_BYTE   (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .frame_cnt (frame_cnt),
        .busy      (busy)
`ifdef SEQ_FRAME_PACKER_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: inspect outputs at negedge, consume handshakes against the scoreboard.
    task automatic tick();
        logic [7:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL spurious_byte: got %h want none", out_data);
            end
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk8("stream", out_data, exp);
            end
        end else if (out_valid) begin
            if (sb.size() != 0) chk8("stall_hold", out_data, sb[0]);
        end else begin
            chk8("idle_zero", out_data, 8'h00);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL %s_timeout: got %0d bytes pending want 0", tag, sb.size());
        end
    endtask

    task automatic expect_frame(input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] s;
        s = p0 + p1 + p2 + p3;
        sb.push_back(8'hA5);
        sb.push_back(p0); sb.push_back(p1); sb.push_back(p2); sb.push_back(p3);
        sb.push_back(s);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        @(posedge clk); #1;

        // 1: reset held, then released idle
        for (int i = 0; i < 3; i++) begin
            if (i == 2) rst = 1'b1;
            tick();
            chk8("rst_valid", 8'(out_valid), 8'h00);
            chk8("rst_busy", 8'(busy), 8'h00);
            chk8("rst_ovf", 8'(overflow), 8'h00);
            chk16("rst_fcnt", frame_cnt, 16'h0000);
        end

        // 2: basic frame
        out_ready = 1'b1;
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        drain("t2");
        chk8("t2_busy", 8'(busy), 8'h00);
        chk16("t2_fcnt", frame_cnt, 16'd1);

        // 3: checksum wrap
        expect_frame(8'hFF, 8'hFF, 8'h01, 8'h02);
        push(8'hFF); push(8'hFF); push(8'h01); push(8'h02);
        drain("t3");
        chk16("t3_fcnt", frame_cnt, 16'd2);

        // 4: overflow with sink stalled
        out_ready = 1'b0;
        expect_frame(8'h10, 8'h11, 8'h12, 8'h13);
        expect_frame(8'h14, 8'h15, 8'h16, 8'h17);
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        chk8("t4_ovf_pre", 8'(overflow), 8'h00);
        push(8'h18);
        chk8("t4_ovf_post", 8'(overflow), 8'h01);
        push(8'h19);
        in_valid = 1'b0;
`ifdef SEQ_FRAME_PACKER_DROP_CNT_EN
        chk8("t4_drop_cnt", drop_cnt, 8'd2);
`endif
        out_ready = 1'b1;
        drain("t4");
        chk16("t4_fcnt", frame_cnt, 16'd4);
        chk8("t4_ovf_sticky", 8'(overflow), 8'h01);

        // 5: sink toggling ready mid-payload
        out_ready = 1'b0;
        expect_frame(8'h01, 8'h02, 8'h03, 8'h04);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk8("t5_hold_valid", 8'(out_valid), 8'h01);
        chk8("t5_hold_data", out_data, 8'h02);
        for (int i = 0; i < 6; i++) begin
            out_ready = (i % 2 == 1);
            tick();
        end
        out_ready = 1'b1;
        drain("t5");
        chk16("t5_fcnt", frame_cnt, 16'd5);

        // 6: reset mid-payload aborts the frame
        out_ready = 1'b0;
        expect_frame(8'h21, 8'h22, 8'h23, 8'h24);
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(); tick(); tick();
        out_ready = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb.delete();
        chk8("t6_valid", 8'(out_valid), 8'h00);
        chk8("t6_busy", 8'(busy), 8'h00);
        chk8("t6_ovf_clr", 8'(overflow), 8'h00);
        chk16("t6_fcnt", frame_cnt, 16'd0);
        tick(); tick();
        chk8("t6_empty", 8'(out_valid), 8'h00);
        chk8("t6_idle", 8'(busy), 8'h00);
        out_ready = 1'b1;
        expect_frame(8'h07, 8'h08, 8'h09, 8'h0A);
        push(8'h07); push(8'h08); push(8'h09); push(8'h0A);
        drain("t6");
        chk16("t6_fcnt_new", frame_cnt, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
